// File: rtl/fsm_event_counter.sv
// Parameterised event counter: tallies qualified Din events modulo MODULO,
// up or down, wrapping or saturating, with clear, load and terminal-count pulse.
module fsm_event_counter #(
  parameter int WIDTH     = 4,
  parameter int MODULO    = 16,
  parameter int SATURATE  = 0,
  parameter int EDGE_MODE = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Din,
  input  logic             En,
  input  logic             Up,
  input  logic             Clear,
  input  logic             Load,
  input  logic [WIDTH-1:0] Load_Val,
  output logic [WIDTH-1:0] Y,
  output logic             Tc,
  output logic             Sat
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_SAT   = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             tc_q, tc_d;
  logic             din_q;
  logic             evt;
  logic             at_bound;
  state_e           resume_state;
  logic [WIDTH-1:0] load_clamped;

  // Din_d keeps tracking Din while disabled, so an edge seen with En=0 is lost.
  if (EDGE_MODE != 0) begin : g_edge
    assign evt = Din & ~din_q;
  end else begin : g_level
    assign evt = Din;
  end

  assign at_bound     = Up ? (y_q == MAX_VAL) : (y_q == '0);
  assign resume_state = En ? S_COUNT : S_IDLE;
  assign load_clamped = (Load_Val > MAX_VAL) ? MAX_VAL : Load_Val;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    y_d     = y_q;
    tc_d    = 1'b0;

    if (Clear) begin
      y_d     = '0;
      state_d = resume_state;
    end else if (Load) begin
      y_d     = load_clamped;
      state_d = resume_state;
    end else if (!En) begin
      state_d = S_IDLE;
    end else begin
      if (state_q == S_IDLE) begin
        state_d = S_COUNT;
      end
      if (evt) begin
        if (!at_bound) begin
          y_d     = Up ? (y_q + WIDTH'(1)) : (y_q - WIDTH'(1));
          state_d = S_COUNT;
        end else if (SATURATE != 0) begin
          // Only the event that first reaches the bound reports a terminal count.
          tc_d    = (state_q != S_SAT);
          state_d = S_SAT;
        end else begin
          y_d     = Up ? '0 : MAX_VAL;
          tc_d    = 1'b1;
          state_d = S_COUNT;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (Reset) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      tc_q    <= 1'b0;
      din_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      tc_q    <= tc_d;
      din_q   <= Din;
    end
  end

  assign Y   = y_q;
  assign Tc  = tc_q;
  assign Sat = (state_q == S_SAT);

endmodule

// File: tb/tb_fsm_event_counter.sv
// Self-checking bench: four counter configurations share one stimulus stream
// and are compared every cycle against an arithmetic reference model.
module tb_fsm_event_counter;

  localparam int N = 4;
  // Per-instance configuration: modulo, saturate, edge mode.
  localparam int CFG_MOD  [N] = '{10, 10, 10, 16};
  localparam int CFG_SAT  [N] = '{0, 1, 0, 1};
  localparam int CFG_EDGE [N] = '{1, 1, 0, 0};

  logic       clk = 1'b0;
  logic       reset, din, en, up, clear, load;
  logic [3:0] load_val;
  logic [3:0] y_w  [N];
  logic       tc_w [N];
  logic       sat_w[N];

  int n_tests = 0;
  int n_fail  = 0;

  int m_y     [N];
  bit m_pinned[N];
  bit m_tc    [N];
  bit m_prev;

  always #5 clk = ~clk;

  fsm_event_counter #(.WIDTH(4), .MODULO(10), .SATURATE(0), .EDGE_MODE(1)) u_wrap (
    .Clk(clk), .Reset(reset), .Din(din), .En(en), .Up(up), .Clear(clear), .Load(load),
    .Load_Val(load_val), .Y(y_w[0]), .Tc(tc_w[0]), .Sat(sat_w[0]));
  fsm_event_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1), .EDGE_MODE(1)) u_sat (
    .Clk(clk), .Reset(reset), .Din(din), .En(en), .Up(up), .Clear(clear), .Load(load),
    .Load_Val(load_val), .Y(y_w[1]), .Tc(tc_w[1]), .Sat(sat_w[1]));
  fsm_event_counter #(.WIDTH(4), .MODULO(10), .SATURATE(0), .EDGE_MODE(0)) u_lvl (
    .Clk(clk), .Reset(reset), .Din(din), .En(en), .Up(up), .Clear(clear), .Load(load),
    .Load_Val(load_val), .Y(y_w[2]), .Tc(tc_w[2]), .Sat(sat_w[2]));
  fsm_event_counter #(.WIDTH(4), .MODULO(16), .SATURATE(1), .EDGE_MODE(0)) u_full (
    .Clk(clk), .Reset(reset), .Din(din), .En(en), .Up(up), .Clear(clear), .Load(load),
    .Load_Val(load_val), .Y(y_w[3]), .Tc(tc_w[3]), .Sat(sat_w[3]));

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: count stays in 0..mod-1; "pinned" means sitting at a bound in saturate mode.
  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      bit evt;
      int nxt;
      evt = (CFG_EDGE[i] != 0) ? (din && !m_prev) : din;
      m_tc[i] = 1'b0;
      if (reset || clear) begin
        m_y[i] = 0;
        m_pinned[i] = 1'b0;
      end else if (load) begin
        m_y[i] = (int'(load_val) > CFG_MOD[i] - 1) ? CFG_MOD[i] - 1 : int'(load_val);
        m_pinned[i] = 1'b0;
      end else if (!en) begin
        m_pinned[i] = 1'b0;
      end else if (evt) begin
        nxt = m_y[i] + (up ? 1 : -1);
        if (nxt >= 0 && nxt < CFG_MOD[i]) begin
          m_y[i] = nxt;
          m_pinned[i] = 1'b0;
        end else if (CFG_SAT[i] != 0) begin
          m_tc[i] = !m_pinned[i];
          m_pinned[i] = 1'b1;
        end else begin
          m_y[i] = (nxt + CFG_MOD[i]) % CFG_MOD[i];
          m_tc[i] = 1'b1;
        end
      end
    end
    m_prev = reset ? 1'b0 : din;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("y[%0d]", i), int'(y_w[i]), m_y[i]);
      check($sformatf("tc[%0d]", i), int'(tc_w[i]), int'(m_tc[i]));
      check($sformatf("sat[%0d]", i), int'(sat_w[i]), int'(m_pinned[i]));
    end
  endtask

  task automatic pulse();
    din = 1'b1;
    tick();
    din = 1'b0;
    tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; din = 1'b0; en = 1'b0; up = 1'b1;
    clear = 1'b0; load = 1'b0; load_val = '0;
    m_prev = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_y[i] = 0; m_pinned[i] = 1'b0; m_tc[i] = 1'b0;
    end
    tick();
    tick();
    check("reset_y", int'(y_w[0]), 0);
    reset = 1'b0;

    // Ten up pulses: the MODULO=10 wrap counter returns to 0 with Tc.
    en = 1'b1; up = 1'b1;
    for (int p = 0; p < 9; p++) pulse();
    din = 1'b1;
    tick();
    check("wrap10_y", int'(y_w[0]), 0);
    check("wrap10_tc", int'(tc_w[0]), 1);
    check("sat10_y", int'(y_w[1]), 9);
    check("sat10_sat", int'(sat_w[1]), 1);
    din = 1'b0;
    tick();
    pulse(); pulse();
    check("sat12_y", int'(y_w[1]), 9);
    up = 1'b0;
    pulse();
    check("sat_down_y", int'(y_w[1]), 8);
    check("sat_down_sat", int'(sat_w[1]), 0);

    // Din held high: one count in edge mode, five in level mode.
    do_clear();
    up = 1'b1; din = 1'b1;
    repeat (5) tick();
    din = 1'b0;
    tick();
    check("hold_edge_y", int'(y_w[0]), 1);
    check("hold_lvl_y", int'(y_w[2]), 5);

    // Down from zero: wrap to MODULO-1 vs saturate at 0.
    do_clear();
    up = 1'b0;
    pulse();
    pulse();

    // Load clamp, Load+Clear priority, Clear out of saturation.
    load = 1'b1; load_val = 4'd12;
    tick();
    check("load_clamp_y", int'(y_w[0]), 9);
    clear = 1'b1;
    tick();
    clear = 1'b0; load = 1'b0;
    up = 1'b1; load = 1'b1; load_val = 4'd15;
    tick();
    load = 1'b0;
    pulse(); pulse();
    do_clear();
    check("clear_sat", int'(sat_w[1]), 0);

    // Disabled pulses, then reset mid-count.
    en = 1'b0;
    pulse(); pulse();
    en = 1'b1;
    repeat (6) pulse();
    din = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    din = 1'b0;
    tick();

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 99) < 2);
      clear    = ($urandom_range(0, 99) < 5);
      load     = ($urandom_range(0, 99) < 6);
      load_val = 4'($urandom);
      en       = ($urandom_range(0, 99) < 88);
      if ($urandom_range(0, 99) < 15) up = ~up;
      din      = $urandom_range(0, 1) == 1;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_event_counter.md
Name: fsm_event_counter

Overview:
- Parameterised successor to the team's 2-bit Din-driven FSM counter.
- Counts events on Din modulo MODULO, up or down, with either wrap or saturate behaviour.
- Adds optional rising-edge qualification of Din, enable, synchronous clear and parallel load, a terminal-count pulse and a saturation flag.
- Sits between a sampled event source and control logic that needs a bounded event tally.

Parameters:
WIDTH, 4, width of count output Y; must satisfy MODULO <= 2**WIDTH
MODULO, 16, count range 0..MODULO-1; legal range 2..2**WIDTH
SATURATE, 0, 0 = wrap at bounds; 1 = stick at bounds
EDGE_MODE, 1, 1 = count Din rising edges; 0 = count every cycle Din is high

Ports:
Clk  input  1  single clock; all state updates on the rising edge
Reset  input  1  synchronous, active-high reset
Din  input  1  event input, synchronous to Clk
En  input  1  count enable
Up  input  1  direction: 1 = increment, 0 = decrement
Clear  input  1  synchronous clear of the count
Load  input  1  synchronous parallel load
Load_Val  input  WIDTH  value loaded when Load=1
Y  output  WIDTH  registered count
Tc  output  1  one-cycle terminal-count pulse
Sat  output  1  high while the FSM is in S_SAT

Behaviour:
- Reset=1 at a Clk edge:
  - State=S_IDLE, Y=0, Tc=0, Sat=0, Din_d=0.
  - Reset overrides all other inputs.
- Event qualification:
  - Din_d registers Din every cycle, including while En=0; a rising edge that occurs while disabled is lost.
  - EDGE_MODE=1: evt = Din & ~Din_d.
  - EDGE_MODE=0: evt = Din.
- Priority, highest first: Reset > Clear > Load > count.
- Clear:
  - Y<=0, Tc<=0.
  - Next state is S_COUNT if En=1, else S_IDLE. This exits S_SAT.
- Load:
  - Y<=Load_Val. If Load_Val >= MODULO, Y<=MODULO-1 (clamp).
  - Tc<=0. Next state is as for Clear.
- FSM states and transitions:
  - S_IDLE (En=0): events ignored, Y holds. Goes to S_COUNT on En=1.
  - S_COUNT (En=1): counts each evt. Goes to S_IDLE on En=0.
  - S_SAT (SATURATE=1 only): Y holds at the bound.
    - Events in the saturating direction are ignored.
    - An event in the opposite direction counts one step and moves to S_COUNT.
    - En=0 moves to S_IDLE, with Sat dropping to 0.
- Latency:
  - evt sampled at edge N updates Y at edge N (visible after edge N).
  - In EDGE_MODE=1, Din rising before edge N counts at edge N.
  - Tc is registered and asserts for exactly the cycle in which Y shows the result of the terminal event.
- Wrap mode (SATURATE=0):
  - Up at Y=MODULO-1 gives Y=0, Tc=1.
  - Down at Y=0 gives Y=MODULO-1, Tc=1.
  - Otherwise Y steps by ±1 with Tc=0.
  - S_SAT is never entered; Sat stays 0.
- Saturate mode (SATURATE=1):
  - Up event at Y=MODULO-1, or down event at Y=0: Y holds, state goes to S_SAT, Sat=1, Tc=1 for that one cycle only.
  - Further same-direction events: Tc=0.
- Arithmetic:
  - All arithmetic is in WIDTH bits, compared against the MODULO-1 constant.
  - Y never leaves 0..MODULO-1.
- Direction change: Up is sampled with each event, so direction may change on any cycle.
- Non-counting cycles: Tc=0 on any cycle with no counting event.
- Reset mid-count: Y returns to 0 on the next edge, any pending Tc is suppressed, and Din_d is cleared. A Din held high through reset therefore counts once after reset in EDGE_MODE=1.

Test Plan:
- Reset, then En=1, Up=1, WIDTH=4, MODULO=10, SATURATE=0, EDGE_MODE=1; ten single-cycle Din pulses -> Y=1..9 then 0; Tc=1 only on the cycle Y becomes 0.
- Same config, Din held high for 5 cycles -> Y increments by exactly 1. With EDGE_MODE=0 the same stimulus gives Y +5.
- SATURATE=1, MODULO=10, Up=1, 12 pulses from 0 -> Y stops at 9. Tc pulses once on the 10th pulse, and Sat stays 1 from then on. One Up=0 pulse -> Y=8, Sat=0.
- Down count in wrap mode from Y=0 -> Y=9, Tc=1. With SATURATE=1 -> Y=0, Sat=1, Tc=1.
- Load_Val=12 with MODULO=10 -> Y=9. Load and Clear asserted together -> Y=0. Clear while in S_SAT -> Sat=0.
- En=0 during pulses -> Y holds. Reset asserted mid-count at Y=6 -> Y=0, Tc=0, Sat=0 on the next edge.
